// File: rtl/panda_uart_pkg.sv
// ============================================================================
// Module   : panda_uart_pkg
// Brief    : Register offsets, STATUS bit indices and TX FSM states for panda_uart_tx.
// Revision : 1.0
// ============================================================================
`default_nettype none

package panda_uart_pkg;

   localparam logic [1:0] TxDataOff  = 2'd0;
   localparam logic [1:0] StatusOff  = 2'd1;
   localparam logic [1:0] BaudDivOff = 2'd2;
   localparam logic [1:0] CtrlOff    = 2'd3;

   localparam int StatFullBit  = 0;
   localparam int StatEmptyBit = 1;
   localparam int StatBusyBit  = 2;
   localparam int StatOvfBit   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_e;

endpackage

`default_nettype wire

// File: rtl/panda_fifo.sv
// ============================================================================
// Module   : panda_fifo
// Brief    : Synchronous first-word-fall-through FIFO; push while full is legal when popping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module panda_fifo #(
   parameter int Width = 8,
   parameter int Depth = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AddrW = $clog2(Depth);
   localparam logic [AddrW:0] FullCount = (AddrW+1)'(Depth);

   logic [Width-1:0] r_mem [Depth];
   logic [AddrW-1:0] r_wr_ptr;
   logic [AddrW-1:0] r_rd_ptr;
   logic [AddrW:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_count == FullCount);
   assign empty     = (r_count == '0);
   assign w_do_push = push & (~full | pop);
   assign w_do_pop  = pop & ~empty;
   assign rdata     = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AddrW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AddrW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AddrW+1)'(1);
            2'b01:   r_count <= r_count - (AddrW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/panda_uart_tx.sv
// ============================================================================
// Module   : panda_uart_tx
// Brief    : Memory-mapped 8N1 UART transmitter with TX FIFO on the panda_core data port.
//            Optional TX-empty interrupt enabled by macro PANDA_UART_TX_IRQ_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module panda_uart_tx
   import panda_uart_pkg::*;
#(
   parameter logic [31:0] BaseAddr   = 32'h0001_0000,
   parameter int          FifoDepth  = 8,
   parameter logic [15:0] DefaultDiv = 16'd867
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   input  logic [3:0]  data_we_i,
   output logic [31:0] data_rdata_o,
   output logic        tx_o,
   output logic        irq_o
);

   logic           w_hit;
   logic [1:0]     w_off;
   logic           w_push_req;
   logic           w_ovf_clr;
   logic           w_ovf_set;
   logic           w_fifo_full;
   logic           w_fifo_empty;
   logic [7:0]     w_fifo_rdata;
   logic           w_pop;
   logic           w_busy;
   logic           w_irq_en;
   logic [31:0]    w_rdata_n;
   logic           w_unused;

   logic [15:0]    r_bauddiv;
   logic           r_ovf;
   logic [31:0]    r_rdata;

   uart_tx_state_e r_state;
   uart_tx_state_e w_state_n;
   logic [7:0]     r_shift;
   logic [7:0]     w_shift_n;
   logic [15:0]    r_cnt;
   logic [15:0]    w_cnt_n;
   logic [2:0]     r_bit;
   logic [2:0]     w_bit_n;
   logic [15:0]    r_div;
   logic [15:0]    w_div_n;
   logic           r_tx;
   logic           w_tx_n;
   logic           w_load;

   assign w_hit      = (data_addr_i[31:4] == BaseAddr[31:4]);
   assign w_off      = data_addr_i[3:2];
   assign w_push_req = w_hit & (w_off == TxDataOff) & data_we_i[0];
   assign w_ovf_clr  = w_hit & (w_off == StatusOff) & data_we_i[0] & data_wdata_i[3];
   // A push into a full FIFO survives only if the serializer frees a slot this cycle.
   assign w_ovf_set  = w_push_req & w_fifo_full & ~w_pop;
   assign w_busy     = (r_state != IDLE);
   assign w_unused   = ^{data_addr_i[1:0], data_wdata_i[31:16], data_we_i[3:2]};

   panda_fifo #(
      .Width (8),
      .Depth (FifoDepth)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (w_push_req),
      .wdata (data_wdata_i[7:0]),
      .pop   (w_pop),
      .rdata (w_fifo_rdata),
      .full  (w_fifo_full),
      .empty (w_fifo_empty)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_bauddiv <= DefaultDiv;
         r_ovf     <= 1'b0;
         r_rdata   <= '0;
      end else begin
         if (w_hit && (w_off == BaudDivOff)) begin
            if (data_we_i[0]) r_bauddiv[7:0]  <= data_wdata_i[7:0];
            if (data_we_i[1]) r_bauddiv[15:8] <= data_wdata_i[15:8];
         end
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
         end
         r_rdata <= w_rdata_n;
      end
   end

`ifdef PANDA_UART_TX_IRQ_EN
   logic r_irq_en;
   logic r_irq;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_irq_en <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_hit && (w_off == CtrlOff) && data_we_i[0]) begin
            r_irq_en <= data_wdata_i[0];
         end
         r_irq <= r_irq_en & w_fifo_empty & ~w_busy;
      end
   end

   assign w_irq_en = r_irq_en;
   assign irq_o    = r_irq;
`else
   assign w_irq_en = 1'b0;
   assign irq_o    = 1'b0;
`endif

   // Read data reflects register state before any same-cycle write.
   always_comb begin
      w_rdata_n = '0;
      if (w_hit) begin
         case (w_off)
            StatusOff: begin
               w_rdata_n[StatOvfBit]   = r_ovf;
               w_rdata_n[StatBusyBit]  = w_busy;
               w_rdata_n[StatEmptyBit] = w_fifo_empty;
               w_rdata_n[StatFullBit]  = w_fifo_full;
            end
            BaudDivOff: w_rdata_n[15:0] = r_bauddiv;
            CtrlOff:    w_rdata_n[0]    = w_irq_en;
            default:    w_rdata_n       = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_div   <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_n;
         r_shift <= w_shift_n;
         r_cnt   <= w_cnt_n;
         r_bit   <= w_bit_n;
         r_div   <= w_div_n;
         r_tx    <= w_tx_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_shift_n = r_shift;
      w_cnt_n   = r_cnt;
      w_bit_n   = r_bit;
      w_div_n   = r_div;
      w_load    = 1'b0;
      w_pop     = 1'b0;
      w_tx_n    = 1'b1;
      case (r_state)
         IDLE: begin
            if (!w_fifo_empty) w_load = 1'b1;
         end
         START: begin
            if (r_cnt == 16'd0) begin
               w_state_n = DATA;
               w_cnt_n   = r_div;
               w_bit_n   = 3'd0;
            end else begin
               w_cnt_n = r_cnt - 16'd1;
            end
         end
         DATA: begin
            if (r_cnt == 16'd0) begin
               w_shift_n = {1'b0, r_shift[7:1]};
               w_cnt_n   = r_div;
               w_bit_n   = r_bit + 3'd1;
               if (r_bit == 3'd7) w_state_n = STOP;
            end else begin
               w_cnt_n = r_cnt - 16'd1;
            end
         end
         STOP: begin
            if (r_cnt == 16'd0) begin
               if (!w_fifo_empty) w_load = 1'b1;
               else               w_state_n = IDLE;
            end else begin
               w_cnt_n = r_cnt - 16'd1;
            end
         end
         default: w_state_n = IDLE;
      endcase
      // Divider is sampled once per frame so mid-frame BAUDDIV writes wait for the next byte.
      if (w_load) begin
         w_state_n = START;
         w_pop     = 1'b1;
         w_shift_n = w_fifo_rdata;
         w_div_n   = r_bauddiv;
         w_cnt_n   = r_bauddiv;
      end
      case (w_state_n)
         START:   w_tx_n = 1'b0;
         DATA:    w_tx_n = w_shift_n[0];
         default: w_tx_n = 1'b1;
      endcase
   end

   assign tx_o         = r_tx;
   assign data_rdata_o = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_panda_uart_tx.sv
// ============================================================================
// Module   : tb_panda_uart_tx
// Brief    : Self-checking bench for panda_uart_tx (waveform-queue reference model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_panda_uart_tx;

   localparam logic [31:0] BASE  = 32'h0001_0000;
   localparam int          DEPTH = 8;
   localparam logic [15:0] DDIV  = 16'd867;
   localparam logic [31:0] A_TX  = BASE;
   localparam logic [31:0] A_ST  = BASE + 32'h4;
   localparam logic [31:0] A_BD  = BASE + 32'h8;
   localparam logic [31:0] A_CT  = BASE + 32'hC;
   localparam logic [31:0] A_UN  = BASE + 32'h20;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic [31:0] addr  = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  we    = '0;
   logic [31:0] rdata;
   logic        tx;
   logic        irq;

   panda_uart_tx #(
      .BaseAddr   (BASE),
      .FifoDepth  (DEPTH),
      .DefaultDiv (DDIV)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .data_addr_i  (addr),
      .data_wdata_i (wdata),
      .data_we_i    (we),
      .data_rdata_o (rdata),
      .tx_o         (tx),
      .irq_o        (irq)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: accepted bytes wait in mq; a started frame becomes one tx level per cycle in wq.
   bit          wq[$];
   logic [7:0]  mq[$];
   logic [15:0] m_div     = DDIV;
   logic        m_ovf     = 1'b0;
   logic        m_irq_en  = 1'b0;
   logic        m_exp_tx  = 1'b1;
   logic [31:0] m_exp_rd  = '0;
   logic        m_exp_irq = 1'b0;

   always @(posedge clk) begin : model
      logic       pre_busy, pre_empty, pre_full, hit, dummy;
      logic [1:0] off;
      logic [7:0] byte_v;
      logic [9:0] frame;
      if (rst) begin
         wq.delete();
         mq.delete();
         m_div     = DDIV;
         m_ovf     = 1'b0;
         m_irq_en  = 1'b0;
         m_exp_tx  = 1'b1;
         m_exp_rd  = '0;
         m_exp_irq = 1'b0;
      end else begin
         pre_busy  = (wq.size() != 0);
         pre_empty = (mq.size() == 0);
         pre_full  = (mq.size() == DEPTH);
         hit       = (addr[31:4] == BASE[31:4]);
         off       = addr[3:2];
         m_exp_rd  = '0;
         if (hit) begin
            case (off)
               2'd1: m_exp_rd = {28'b0, m_ovf, pre_busy, pre_empty, pre_full};
               2'd2: m_exp_rd = {16'b0, m_div};
`ifdef PANDA_UART_TX_IRQ_EN
               2'd3: m_exp_rd = {31'b0, m_irq_en};
`endif
               default: m_exp_rd = '0;
            endcase
         end
`ifdef PANDA_UART_TX_IRQ_EN
         m_exp_irq = m_irq_en & pre_empty & ~pre_busy;
`endif
         if (wq.size() != 0) dummy = wq.pop_front();
         if (wq.size() == 0 && mq.size() != 0) begin
            byte_v = mq.pop_front();
            frame  = {1'b1, byte_v, 1'b0};
            for (int b = 0; b < 10; b++)
               for (int c = 0; c <= int'(m_div); c++)
                  wq.push_back(frame[b]);
         end
         if (hit && we[0]) begin
            case (off)
               2'd0: if (mq.size() < DEPTH) mq.push_back(wdata[7:0]); else m_ovf = 1'b1;
               2'd1: if (wdata[3]) m_ovf = 1'b0;
`ifdef PANDA_UART_TX_IRQ_EN
               2'd3: m_irq_en = wdata[0];
`endif
               default: ;
            endcase
         end
         if (hit && off == 2'd2) begin
            if (we[0]) m_div[7:0]  = wdata[7:0];
            if (we[1]) m_div[15:8] = wdata[15:8];
         end
         m_exp_tx = (wq.size() != 0) ? wq[0] : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("model_tx_o", {31'b0, tx}, {31'b0, m_exp_tx});
         chk("model_rdata", rdata, m_exp_rd);
         chk("model_irq_o", {31'b0, irq}, {31'b0, m_exp_irq});
      end
   end

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      addr  = a;
      wdata = d;
      we    = w;
      @(negedge clk);
      we    = '0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      addr = a;
      we   = '0;
      @(negedge clk);
      v = rdata;
   endtask

   initial begin
      logic [31:0] v;
      logic [9:0]  fa5;
      int          busy_n;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_tx", {31'b0, tx}, 32'h1);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_irq", {31'b0, irq}, 32'h0);
      rst = 1'b0;

      // Register reads straight out of reset, unmapped access
      rd(A_ST, v);  chk("status_reset", v, 32'h2);
      rd(A_BD, v);  chk("bauddiv_reset", v, 32'd867);
      wr(A_UN, 32'hFF, 4'hF);
      rd(A_UN, v);  chk("unmapped_read", v, 32'h0);
      rd(A_BD, v);  chk("bauddiv_after_unmapped", v, 32'd867);
      rd(A_ST, v);  chk("status_after_unmapped", v, 32'h2);
      rd(A_CT, v);  chk("ctrl_reset", v, 32'h0);

      // Single 0xA5 frame at 4 clk per bit
      wr(A_BD, 32'd3, 4'b0011);
      wr(A_TX, 32'hA5, 4'b0001);
      addr   = A_ST;
      fa5    = {1'b1, 8'hA5, 1'b0};
      busy_n = 0;
      chk("t1_idle_before", {31'b0, tx}, 32'h1);
      for (int k = 1; k < 48; k++) begin
         @(negedge clk);
         busy_n += int'(rdata[2]);
         if (k <= 40) chk("t1_frame_bit", {31'b0, tx}, {31'b0, fa5[(k-1)/4]});
         else         chk("t1_idle_after", {31'b0, tx}, 32'h1);
      end
      chk("t1_busy_cycles", busy_n, 32'd40);
      chk("t1_status_end", rdata, 32'h2);

      // Fill to full while the first byte serializes, then overflow
      for (int i = 0; i < 9; i++) wr(A_TX, 32'h10 + i, 4'b0001);
      rd(A_ST, v);  chk("t2_nine_accepted", v, 32'h5);
      wr(A_TX, 32'h99, 4'b0001);
      rd(A_ST, v);  chk("t2_ovf_set", v, 32'hD);
      wr(A_ST, 32'h8, 4'b0001);
      rd(A_ST, v);  chk("t2_ovf_clear", v, 32'h5);
      repeat (370) @(negedge clk);
      rd(A_ST, v);  chk("t2_drained", v, 32'h2);

      // BAUDDIV change mid-frame affects only the queued byte
      wr(A_TX, 32'h55, 4'b0001);
      wr(A_TX, 32'h33, 4'b0001);
      repeat (10) @(negedge clk);
      wr(A_BD, 32'd7, 4'b0011);
      repeat (92) @(negedge clk);
      rd(A_ST, v);  chk("t4_second_frame_slow", v, 32'h6);
      repeat (20) @(negedge clk);
      rd(A_ST, v);  chk("t4_done", v, 32'h2);

      // Asynchronous reset in the middle of a data bit
      wr(A_TX, 32'h00, 4'b0001);
      repeat (15) @(negedge clk);
      chk("t5_data_bit_low", {31'b0, tx}, 32'h0);
      #2 rst = 1'b1;
      #1;
      chk("t5_async_tx_high", {31'b0, tx}, 32'h1);
      chk("t5_async_rdata_zero", rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      rd(A_BD, v);  chk("t5_bauddiv_default", v, 32'd867);
      rd(A_ST, v);  chk("t5_fifo_empty", v, 32'h2);
      wr(A_BD, 32'd1, 4'b0011);
      wr(A_TX, 32'h3C, 4'b0001);
      repeat (25) @(negedge clk);
      rd(A_ST, v);  chk("t5_clean_frame_done", v, 32'h2);

      // Interrupt enable
      wr(A_CT, 32'h1, 4'b0001);
      repeat (3) @(negedge clk);
      rd(A_CT, v);
`ifdef PANDA_UART_TX_IRQ_EN
      chk("t6_ctrl_readback", v, 32'h1);
      chk("t6_irq_idle", {31'b0, irq}, 32'h1);
      wr(A_TX, 32'h81, 4'b0001);
      @(negedge clk);
      chk("t6_irq_fell", {31'b0, irq}, 32'h0);
      repeat (25) @(negedge clk);
      chk("t6_irq_rose", {31'b0, irq}, 32'h1);
`else
      chk("t6_ctrl_reads_zero", v, 32'h0);
      wr(A_TX, 32'h81, 4'b0001);
      repeat (25) @(negedge clk);
      chk("t6_irq_tied_low", {31'b0, irq}, 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
